ds_decimator: RTL and testbench

DS_DECIMATOR -- requirements
Module: ds_decimator

---
 rtl/ds_decimator_pkg.sv | 22 ++
 rtl/ds_decimator_clk_en.sv | 23 ++
 rtl/ds_decimator.sv | 139 +++++++++++++
 tb/tb_ds_decimator.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ds_decimator_pkg.sv
// Shared constants and helpers for the delta-sigma audio path (decimator and DAC side).
package ds_pkg;

  localparam int AUDIO_W   = 14;
  localparam int CIC_ORDER = 3;
  localparam int DCB_W     = 22;

  localparam logic signed [AUDIO_W-1:0] AUDIO_MAX = 14'sh1FFF;
  localparam logic signed [AUDIO_W-1:0] AUDIO_MIN = 14'sh2000;

  // Integrator width that cannot overflow ambiguously: order*log2(R) plus sign headroom.
  function automatic int cic_width(input int decim_log2);
    return CIC_ORDER * decim_log2 + 2;
  endfunction

  function automatic logic signed [AUDIO_W-1:0] sat_audio(input logic signed [31:0] v);
    if (v > 32'sd8191)       return AUDIO_MAX;
    else if (v < -32'sd8192) return AUDIO_MIN;
    else                     return v[AUDIO_W-1:0];
  endfunction

endpackage

// File: rtl/ds_decimator_clk_en.sv
// Bit-rate enable: one-clock pulse every CLK_DIV system clocks.
module ds_clk_en #(
  parameter int CLK_DIV = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic en
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign en = (r_cnt == CW'(CLK_DIV - 1));

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i)   r_cnt <= '0;
    else if (en) r_cnt <= '0;
    else         r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/ds_decimator.sv
// 3rd-order CIC decimator turning a 1-bit delta-sigma stream into 14-bit PCM.
// Define DS_DECIM_DCBLOCK_EN to add a first-order DC blocker (+1 clk latency).
module ds_decimator
  import ds_pkg::*;
#(
  parameter int CLK_DIV    = 5,
  parameter int DECIM_LOG2 = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      bit_i,
  output logic signed [AUDIO_W-1:0] audio_o,
  output logic                      audio_valid_o
);

  localparam int W     = cic_width(DECIM_LOG2);
  localparam int SHIFT = CIC_ORDER * DECIM_LOG2 - 13;

  logic w_en;

  ds_clk_en #(.CLK_DIV(CLK_DIV)) u_clk_en (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (w_en)
  );

  logic signed [W-1:0]    r_int1, r_int2, r_int3;
  logic signed [W-1:0]    r_cap, r_d1, r_d2, r_d3, r_comb;
  logic [DECIM_LOG2-1:0]  r_dcnt;
  logic [1:0]             r_settle;
  logic                   r_cap_vld, r_cap_live, r_comb_live;

  logic signed [W-1:0]    w_x, w_int3_next, w_c1, w_c2, w_c3, w_shift;
  logic signed [31:0]     w_scaled;
  logic signed [AUDIO_W-1:0] w_sat;
  logic                   w_tick, w_settled;

  assign w_x         = bit_i ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
  assign w_int3_next = r_int3 + r_int2;
  // R is a power of two, so the last count is all ones and the counter wraps by itself.
  assign w_tick      = w_en && (r_dcnt == '1);
  assign w_settled   = (r_settle == 2'd3);

  assign w_c1     = r_cap - r_d1;
  assign w_c2     = w_c1 - r_d2;
  assign w_c3     = w_c2 - r_d3;
  assign w_shift  = r_comb >>> SHIFT;
  assign w_scaled = 32'(w_shift);
  assign w_sat    = sat_audio(w_scaled);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_int1      <= '0;
      r_int2      <= '0;
      r_int3      <= '0;
      r_dcnt      <= '0;
      r_settle    <= '0;
      r_cap       <= '0;
      r_cap_vld   <= 1'b0;
      r_cap_live  <= 1'b0;
      r_d1        <= '0;
      r_d2        <= '0;
      r_d3        <= '0;
      r_comb      <= '0;
      r_comb_live <= 1'b0;
    end else begin
      if (w_en) begin
        r_int1 <= r_int1 + w_x;
        r_int2 <= r_int2 + r_int1;
        r_int3 <= w_int3_next;
        r_dcnt <= r_dcnt + DECIM_LOG2'(1);
      end
      r_cap_vld  <= w_tick;
      r_cap_live <= w_tick && w_settled;
      if (w_tick) begin
        r_cap <= w_int3_next;
        if (!w_settled) r_settle <= r_settle + 2'd1;
      end
      // Combs run on every tick, settling ones included, so their delays are primed.
      r_comb_live <= r_cap_live;
      if (r_cap_vld) begin
        r_d1   <= r_cap;
        r_d2   <= w_c1;
        r_d3   <= w_c2;
        r_comb <= w_c3;
      end
    end
  end

`ifdef DS_DECIM_DCBLOCK_EN
  logic signed [DCB_W-1:0]   r_dc_y, w_dc_next, w_dc_xs, w_dc_x1s, w_dc_out;
  logic signed [AUDIO_W-1:0] r_dc_x1;
  logic signed [DCB_W+1:0]   w_dc_sum;
  logic                      r_dc_live;

  // Input carries 8 fraction bits so the y>>>8 leak keeps sub-LSB resolution.
  assign w_dc_xs  = {w_sat, 8'h00};
  assign w_dc_x1s = {r_dc_x1, 8'h00};
  assign w_dc_sum = (DCB_W+2)'(w_dc_xs) - (DCB_W+2)'(w_dc_x1s)
                  + (DCB_W+2)'(r_dc_y) - (DCB_W+2)'(r_dc_y >>> 8);
  assign w_dc_out = r_dc_y >>> 8;

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    w_dc_next = w_dc_sum[DCB_W-1:0];
    if (w_dc_sum > 24'sd2097151)       w_dc_next = 22'sh1FFFFF;
    else if (w_dc_sum < -24'sd2097152) w_dc_next = 22'sh200000;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dc_y        <= '0;
      r_dc_x1       <= '0;
      r_dc_live     <= 1'b0;
      audio_o       <= '0;
      audio_valid_o <= 1'b0;
    end else begin
      r_dc_live <= r_comb_live;
      if (r_comb_live) begin
        r_dc_y  <= w_dc_next;
        r_dc_x1 <= w_sat;
      end
      audio_valid_o <= r_dc_live;
      if (r_dc_live) audio_o <= sat_audio(32'(w_dc_out));
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      audio_o       <= '0;
      audio_valid_o <= 1'b0;
    end else begin
      audio_valid_o <= r_comb_live;
      if (r_comb_live) audio_o <= w_sat;
    end
  end
`endif

endmodule

// File: tb/tb_ds_decimator.sv
// Directed bench for ds_decimator (default build): latency, scaling, saturation, reset abort.
module tb_ds_decimator;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               bit_i = 1'b0;
  logic signed [13:0] audio_o;
  logic               audio_valid_o;

  ds_decimator dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .bit_i         (bit_i),
    .audio_o       (audio_o),
    .audio_valid_o (audio_valid_o)
  );

  always #5 clk_i = ~clk_i;

  localparam int CLK_DIV    = 5;
  localparam int PERIOD     = 256 * CLK_DIV;
  localparam int FIRST_EDGE = 4 * PERIOD + 2;

  typedef struct {
    string name;
    int    mode;
    int    exp_val;
    int    tol;
  } vec_t;

  vec_t vecs[4];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   edge_cnt = 0;
  int   mode     = 0;
  int   en_idx   = 0;

  // Clock edges since reset release; the DUT's bit enable falls in cycles with count%5==4.
  always @(posedge clk_i) begin
    if (rst_i) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  function automatic logic pat_bit(input int m, input int k);
    case (m)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (k % 2) == 0;
      default: return (k % 4) != 3;
    endcase
  endfunction

  // Pattern bits on enable cycles, random junk on all other cycles.
  always @(negedge clk_i) begin
    if (rst_i) begin
      en_idx = 0;
    end else if (edge_cnt % CLK_DIV == CLK_DIV - 1) begin
      bit_i  = pat_bit(mode, en_idx);
      en_idx = en_idx + 1;
    end else begin
      bit_i = 1'($urandom);
    end
  end

  task automatic check(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if (act < exp - tol || act > exp + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic wait_strobe(input int budget, output int at, output int val);
    at  = -1;
    val = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (audio_valid_o) begin
        at  = edge_cnt;
        val = int'(audio_o);
        return;
      end
    end
  endtask

  task automatic apply_reset(input int m);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    mode = m;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    int at, val, prev_at;

    vecs[0] = '{name: "const_one",  mode: 0, exp_val:  8191, tol: 0};
    vecs[1] = '{name: "const_zero", mode: 1, exp_val: -8192, tol: 0};
    vecs[2] = '{name: "alt_10",     mode: 2, exp_val:     0, tol: 1};
    vecs[3] = '{name: "pat_1110",   mode: 3, exp_val:  4096, tol: 2};

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_audio", int'(audio_o), 0, 0);
    check("reset_valid", int'(audio_valid_o), 0, 0);

    foreach (vecs[r]) begin
      apply_reset(vecs[r].mode);
      wait_strobe(FIRST_EDGE + 50, at, val);
      check({vecs[r].name, "_first_edge"}, at, FIRST_EDGE, 0);
      check({vecs[r].name, "_val0"}, val, vecs[r].exp_val, vecs[r].tol);
      @(negedge clk_i);
      check({vecs[r].name, "_strobe_width"}, int'(audio_valid_o), 0, 0);
      check({vecs[r].name, "_hold"}, int'(audio_o), val, 0);
      for (int j = 1; j <= 2; j++) begin
        prev_at = at;
        wait_strobe(PERIOD + 50, at, val);
        check({vecs[r].name, "_spacing"}, at - prev_at, PERIOD, 0);
        check({vecs[r].name, "_valn"}, val, vecs[r].exp_val, vecs[r].tol);
      end
    end

    // Reset pulse landing on the edge that would have raised the second strobe.
    apply_reset(0);
    wait_strobe(FIRST_EDGE + 50, at, val);
    check("abort_first_edge", at, FIRST_EDGE, 0);
    check("abort_first_val", val, 8191, 0);
    for (int i = 0; i < PERIOD; i++) begin
      @(posedge clk_i);
      #1;
      if (edge_cnt == FIRST_EDGE + PERIOD - 1) break;
    end
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("abort_valid", int'(audio_valid_o), 0, 0);
    check("abort_audio", int'(audio_o), 0, 0);
    wait_strobe(FIRST_EDGE + 50, at, val);
    check("abort_resettle_edge", at, FIRST_EDGE, 0);
    check("abort_resettle_val", val, 8191, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
